// File: rtl/sync_gray_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_gray_fifo_pkg
// Shared defaults and helpers for the single-clock Gray-pointer FIFO.
//   DATA_WIDTH_DEF : default data width in bits
//   ADDR_WIDTH_DEF : default log2 of the FIFO depth
//   DEPTH          : entry count for the default address width
//   bin2gray()     : binary to reflected-Gray conversion
// -----------------------------------------------------------------------------
package sync_gray_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DEPTH          = 1 << ADDR_WIDTH_DEF;

    // Works on a 32-bit container so it can serve any pointer width.
    // Callers size-cast the result down to their own pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// 2**ADDR_WIDTH x DATA_WIDTH storage. It has a synchronous write port and a
// registered read port.
// Ports:
//   CLK    : clock, rising edge
//   RST    : asynchronous active-high reset (clears the read register only)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata is updated on the next edge
//   raddr  : read address
//   rdata  : registered read data; holds its value when re is low
// -----------------------------------------------------------------------------
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // The storage array is not reset, so it maps onto plain RAM.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_gray_fifo.sv
// -----------------------------------------------------------------------------
// sync_gray_fifo
// Single-clock FIFO. The binary read and write pointers have an extra wrap bit.
// Each pointer also keeps a registered Gray copy, and the full and empty flags
// are decoded from the Gray copies. This lets the block be split into a
// dual-clock FIFO later without changing its interface.
// Optional feature (macro FIFO_LEVEL_EN): adds an occupancy output 'level'.
// Ports:
//   CLK    : clock, rising edge
//   RST    : asynchronous active-high reset
//   write  : write request, accepted when write && !full
//   wdata  : write data
//   read   : read request, accepted when read && !empty
//   rdata  : registered read data, one cycle after the accepting edge
//   full   : FIFO holds 2**ADDR_WIDTH entries
//   empty  : FIFO holds no entries
//   level  : (FIFO_LEVEL_EN only) occupancy, wptr - rptr
// -----------------------------------------------------------------------------
module sync_gray_fifo
    import sync_gray_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  write,
    input  logic                  read,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
`ifdef FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH:0] wptr, rptr;
    logic [ADDR_WIDTH:0] wgray, rgray;
    logic [ADDR_WIDTH:0] wptr_nxt, rptr_nxt;
    logic                wr_en, rd_en;

    // Both requests are judged against the flags as they stood before the edge.
    assign wr_en    = write && !full;
    assign rd_en    = read && !empty;
    assign wptr_nxt = wptr + PW'(1);
    assign rptr_nxt = rptr + PW'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr  <= '0;
            wgray <= '0;
        end else if (wr_en) begin
            wptr  <= wptr_nxt;
            wgray <= PW'(bin2gray(32'(wptr_nxt)));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rptr  <= '0;
            rgray <= '0;
        end else if (rd_en) begin
            rptr  <= rptr_nxt;
            rgray <= PW'(bin2gray(32'(rptr_nxt)));
        end
    end

    // In Gray code, pointers one full lap apart differ only in their top two bits.
    assign empty = (wgray == rgray);
    assign full  = (wgray == {~rgray[ADDR_WIDTH:ADDR_WIDTH-1], rgray[ADDR_WIDTH-2:0]});

`ifdef FIFO_LEVEL_EN
    assign level = wptr - rptr;
`endif

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .CLK   (CLK),
        .RST   (RST),
        .we    (wr_en),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_gray_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_gray_fifo
// Self-checking bench for sync_gray_fifo. A queue model tracks the FIFO
// contents. A negedge process compares the flags and rdata against that model
// on every cycle. Directed sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_sync_gray_fifo;

    logic       CLK = 1'b0;
    logic       RST;
    logic       write, read;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       full, empty;
`ifdef FIFO_LEVEL_EN
    logic [4:0] level;
`endif

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [7:0] mq[$];
    logic [7:0] m_rdata;

    sync_gray_fifo dut (
        .CLK   (CLK),
        .RST   (RST),
        .write (write),
        .read  (read),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
`ifdef FIFO_LEVEL_EN
        ,
        .level (level)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: occupancy decisions come from the queue size before the edge.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mq.delete();
            m_rdata = 8'h00;
        end else begin
            automatic bit do_w = write && (mq.size() < 16);
            automatic bit do_r = read && (mq.size() > 0);
            if (do_r) m_rdata = mq.pop_front();
            if (do_w) mq.push_back(wdata);
        end
    end

    always @(negedge CLK) begin
        if (chk_en && !RST) begin
            chk("model_empty", 32'(empty), 32'(mq.size() == 0));
            chk("model_full",  32'(full),  32'(mq.size() == 16));
            chk("model_rdata", 32'(rdata), 32'(m_rdata));
`ifdef FIFO_LEVEL_EN
            chk("model_level", 32'(level), 32'(mq.size()));
`endif
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        write = w;
        read  = r;
        wdata = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST   = 1'b1;
        write = 1'b0;
        read  = 1'b0;
        wdata = 8'h00;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        chk_en = 1'b1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
`ifdef FIFO_LEVEL_EN
        chk("rst_level", 32'(level), 32'd0);
`endif

        // Fill with 1..16, then an extra write of 17 must be ignored.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            chk("fill_empty", 32'(empty), 32'd0);
        end
        chk("fill_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b0, 8'd17);
        chk("fill_over_full", 32'(full), 32'd1);

        // Drain: 1..16 in order. Further reads hold rdata at 16.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("drain_data", 32'(rdata), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        chk("drain_hold", 32'(rdata), 32'd16);

        // Streaming across the pointer wrap with occupancy 1.
        cyc(1'b1, 1'b0, 8'd1);
        for (int k = 1; k <= 40; k++) begin
            cyc(1'b1, 1'b1, 8'(k + 1));
            chk("stream_data",  32'(rdata), 32'(k));
            chk("stream_empty", 32'(empty), 32'd0);
            chk("stream_full",  32'(full),  32'd0);
        end
        cyc(1'b0, 1'b1, 8'h00);
        chk("stream_last", 32'(rdata), 32'd41);
        chk("stream_end_empty", 32'(empty), 32'd1);

        // Full with read and write both high: only the read is taken.
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(100 + i));
        chk("bfull_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b1, 8'd200);
        chk("bfull_rdata", 32'(rdata), 32'd101);
        chk("bfull_drop", 32'(full), 32'd0);
        for (int i = 2; i <= 16; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("bfull_tail", 32'(rdata), 32'd116);
        chk("bfull_drained", 32'(empty), 32'd1);

        // Empty with both high: only the write is taken, and rdata is unchanged.
        cyc(1'b1, 1'b1, 8'd55);
        chk("bempty_empty", 32'(empty), 32'd0);
        chk("bempty_rdata", 32'(rdata), 32'd116);
        cyc(1'b0, 1'b1, 8'h00);
        chk("bempty_read", 32'(rdata), 32'd55);
        chk("bempty_again", 32'(empty), 32'd1);

        // Reset mid-operation with 5 entries stored.
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 8'(60 + i));
        write = 1'b0;
        #1 RST = 1'b1;
        #1;
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_full",  32'(full),  32'd0);
        #1 RST = 1'b0;
        cyc(1'b1, 1'b0, 8'hAA);
        cyc(1'b0, 1'b1, 8'h00);
        chk("midrst_data", 32'(rdata), 32'hAA);
        chk("midrst_empty2", 32'(empty), 32'd1);

        cyc(1'b0, 1'b0, 8'h00);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
